network_tx_interface: RTL and testbench
=======================================

Name: network_tx_interface

Overview:
- Transmit-side network interface: host pushes flits into a tx buffer; the block forwards them to the local router port with a valid/ready handshake.
- Store-and-forward at packet granularity. A packet is released to the router only after its tail flit is buffered, so a packet never stalls mid-stream on host starvation.
- Sits between the host message path and the router injection port. It is the counterpart of the rx network interface.

Parameters:
- FLIT_WIDTH, 64, flit width in bits.
- DEPTH_LOG2, 6, log2 of buffer entries (DEPTH = 64).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- host_flit  in  FLIT_WIDTH  flit from host.
- host_tail  in  1  marks host_flit as last flit of a packet.
- host_we  in  1  host write strobe.
- host_ready  out  1  buffer can accept a flit this cycle.
- flit_out  out  FLIT_WIDTH  flit to router.
- tail_out  out  1  flit_out is a tail flit.
- valid_out  out  1  flit_out valid.
- out_ready  in  1  router accepts flit_out this cycle.
- tx_state  out  2  buffer state: EMPTY=0, VACANT=1, FULL=2.
- count  out  DEPTH_LOG2+1  flits held.
- pkt_count  out  DEPTH_LOG2+1  complete packets held.
- overflow  out  1  one-cycle pulse when host_we is asserted while host_ready=0.
- stuck_err  out  1  sticky: buffer full with pkt_count=0.

Behaviour:
- Reset (rst high at posedge): wr_ptr=rd_ptr=0, count=0, pkt_count=0, FSM=IDLE, overflow=0, stuck_err=0. Outputs then read tx_state=EMPTY, host_ready=1, valid_out=0. Buffer contents are don't-care.
- Storage: circular buffer, DEPTH entries of {tail, flit}. Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
- host_ready = (count != DEPTH); combinational from registered count.
- Push = host_we & host_ready. On push, write mem[wr_ptr], then wr_ptr+1 and count+1.
- Push with host_tail=1: pkt_count+1.
- host_we & !host_ready: no write, no pointer change; overflow=1 in the next cycle only.
- FSM states: IDLE, SEND.
  - IDLE: valid_out=0. Go to SEND at the next edge if registered pkt_count != 0.
  - SEND: valid_out=1, flit_out/tail_out = mem[rd_ptr] (combinational read of head).
- Pop = valid_out & out_ready. On pop, rd_ptr+1 and count-1.
- Pop of a tail flit: pkt_count-1, and FSM returns to IDLE. This gives a mandatory one-cycle gap between packets.
- While valid_out=1 and out_ready=0: flit_out and tail_out are held stable. The FSM stays in SEND; no flit is dropped.
- Simultaneous push and pop: count unchanged, both pointers advance. Simultaneous tail push and tail pop: pkt_count unchanged.
- Push into slot just vacated: allowed only when count != DEPTH before the edge. host_ready does not look ahead to a same-cycle pop.
- tx_state from registered count: EMPTY if 0, FULL if DEPTH, else VACANT.
- stuck_err: set when count == DEPTH and pkt_count == 0 (a packet larger than the buffer). Cleared only by rst. The block then deadlocks by design; recovery is by reset.
- Latency: tail sampled at edge N gives pkt_count=1 after N, SEND after N+1, so valid_out is high in the cycle after N+1. Minimum host-to-router latency is 2 cycles from the tail edge.
- Reset mid-packet: all buffered flits are discarded. valid_out drops to 0 in the cycle after the rst edge.

Test Plan:
- Reset, then idle 5 cycles -> valid_out=0, host_ready=1, tx_state=EMPTY, count=0, overflow=0, stuck_err=0.
- Push 3-flit packet A0,A1,A2 (tail on A2), out_ready=1 -> valid_out rises 2 edges after the A2 push. A0,A1,A2 appear on consecutive cycles with tail_out=1 only on A2. Then valid_out=0 for ≥1 cycle; count returns to 0.
- Same packet with out_ready=0 for 4 cycles after valid_out rises -> A0 held stable for all 4 cycles. Order is preserved once out_ready=1; no loss.
- Push two 32-flit packets with out_ready=0 -> count=64, tx_state=FULL, host_ready=0, pkt_count=2. An extra host_we gives overflow pulsed for exactly 1 cycle and count stays 64.
- Push 64 flits with no tail -> stuck_err=1, valid_out stays 0. Reset -> stuck_err=0, count=0.
- In SEND with out_ready=1, push a 2-flit packet B while popping packet A's tail -> count and pkt_count stay consistent; B follows after the 1-cycle gap. Then assert rst while B1 is pending -> valid_out=0 the next cycle and count=0.

Source files
------------

// File: rtl/network_tx_interface.sv
// Transmit network interface: buffers host flits and releases whole packets to the
// router injection port once their tail flit has been stored.
module network_tx_interface #(
  parameter int FLIT_WIDTH = 64,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] host_flit,
  input  logic                  host_tail,
  input  logic                  host_we,
  output logic                  host_ready,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  tail_out,
  output logic                  valid_out,
  input  logic                  out_ready,
  output logic [1:0]            tx_state,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   pkt_count,
  output logic                  overflow,
  output logic                  stuck_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {IDLE, SEND} state_e;
  typedef enum logic [1:0] {TX_EMPTY = 2'd0, TX_VACANT = 2'd1, TX_FULL = 2'd2} tx_state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [DEPTH_LOG2:0]     pkt_count_q, pkt_count_d;
  logic                    overflow_q, overflow_d;
  logic                    stuck_err_q, stuck_err_d;

  // Each entry is {tail, flit}.
  logic [FLIT_WIDTH:0]     mem [DEPTH];
  logic [FLIT_WIDTH:0]     head;
  logic                    push, pop, tail_push, tail_pop;

  assign host_ready = (count_q != CNT_FULL);
  assign valid_out  = (state_q == SEND);
  assign head       = mem[rd_ptr_q];
  assign flit_out   = head[FLIT_WIDTH-1:0];
  assign tail_out   = head[FLIT_WIDTH];

  assign push      = host_we & host_ready;
  assign pop       = valid_out & out_ready;
  assign tail_push = push & host_tail;
  assign tail_pop  = pop & tail_out;

  assign count     = count_q;
  assign pkt_count = pkt_count_q;
  assign overflow  = overflow_q;
  assign stuck_err = stuck_err_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    tx_state    = TX_VACANT;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    unique case ({tail_push, tail_pop})
      2'b10:   pkt_count_d = pkt_count_q + CNT_ONE;
      2'b01:   pkt_count_d = pkt_count_q - CNT_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase

    // Returning to IDLE after each tail enforces the inter-packet gap.
    unique case (state_q)
      IDLE:    if (pkt_count_q != '0) state_d = SEND;
      SEND:    if (tail_pop)          state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (count_q == '0)          tx_state = TX_EMPTY;
    else if (count_q == CNT_FULL) tx_state = TX_FULL;

    overflow_d  = host_we & ~host_ready;
    // A full buffer with no complete packet can never drain; only reset recovers it.
    stuck_err_d = stuck_err_q | ((count_q == CNT_FULL) && (pkt_count_q == '0));
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      overflow_q  <= 1'b0;
      stuck_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      overflow_q  <= overflow_d;
      stuck_err_q <= stuck_err_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {host_tail, host_flit};
  end

endmodule

// File: tb/tb_network_tx_interface.sv
// Scoreboard bench for network_tx_interface: directed packets, flow control,
// full/overflow, stuck detection and reset mid-packet.
module tb_network_tx_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] host_flit;
  logic        host_tail;
  logic        host_we;
  logic        host_ready;
  logic [63:0] flit_out;
  logic        tail_out;
  logic        valid_out;
  logic        out_ready;
  logic [1:0]  tx_state;
  logic [6:0]  count;
  logic [6:0]  pkt_count;
  logic        overflow;
  logic        stuck_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [64:0] sb [$];

  network_tx_interface #(.FLIT_WIDTH(64), .DEPTH_LOG2(6)) dut (
    .clk(clk), .rst(rst),
    .host_flit(host_flit), .host_tail(host_tail), .host_we(host_we), .host_ready(host_ready),
    .flit_out(flit_out), .tail_out(tail_out), .valid_out(valid_out), .out_ready(out_ready),
    .tx_state(tx_state), .count(count), .pkt_count(pkt_count),
    .overflow(overflow), .stuck_err(stuck_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] f, input logic t);
    host_we   = 1'b1;
    host_flit = f;
    host_tail = t;
    sb.push_back({t, f});
    tick();
    host_we   = 1'b0;
    host_tail = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    check(name, 64'(sb.size() == 0), 64'd1);
  endtask

  // Monitor: compares every accepted flit against the scoreboard and checks the gap after a tail.
  initial begin
    logic        prev_tail_pop;
    logic [64:0] exp;
    prev_tail_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev_tail_pop = 1'b0;
      else begin
        if (prev_tail_pop) check("gap_after_tail", 64'(valid_out), 64'd0);
        prev_tail_pop = 1'b0;
        if (valid_out && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL pop_unexpected: got flit %0h expected no flit (t=%0t)", flit_out, $time);
          end else begin
            exp = sb.pop_front();
            check("pop_flit", flit_out, exp[63:0]);
            check("pop_tail", 64'(tail_out), 64'(exp[64]));
            prev_tail_pop = tail_out;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; host_flit = '0; host_tail = 1'b0; host_we = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_valid",     64'(valid_out),  64'd0);
    check("rst_ready",     64'(host_ready), 64'd1);
    check("rst_state",     64'(tx_state),   64'd0);
    check("rst_count",     64'(count),      64'd0);
    check("rst_overflow",  64'(overflow),   64'd0);
    check("rst_stuck",     64'(stuck_err),  64'd0);

    // Packet A streams straight through; valid rises two edges after the tail push.
    out_ready = 1'b1;
    push(64'hA0, 1'b0);
    push(64'hA1, 1'b0);
    push(64'hA2, 1'b1);
    check("a_valid_lat1",  64'(valid_out), 64'd0);
    check("a_pkt_count",   64'(pkt_count), 64'd1);
    check("a_count",       64'(count),     64'd3);
    check("a_state_vac",   64'(tx_state),  64'd1);
    tick();
    check("a_valid_lat2",  64'(valid_out), 64'd1);
    check("a_head",        flit_out,       64'hA0);
    repeat (3) tick();
    check("a_valid_end",   64'(valid_out), 64'd0);
    check("a_count_end",   64'(count),     64'd0);
    check("a_pkt_end",     64'(pkt_count), 64'd0);

    // Backpressure: head held stable for 4 cycles, then drained in order.
    out_ready = 1'b0;
    push(64'hB0, 1'b0);
    push(64'hB1, 1'b0);
    push(64'hB2, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 64'(valid_out), 64'd1);
      check("bp_hold",  flit_out,       64'hB0);
      check("bp_tail",  64'(tail_out),  64'd0);
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_count_end", 64'(count), 64'd0);

    // Fill with two 32-flit packets, then one rejected write.
    out_ready = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 32; i++)
        push(64'(32'hC000 + p * 32 + i), i == 31);
    check("full_count",  64'(count),      64'd64);
    check("full_state",  64'(tx_state),   64'd2);
    check("full_ready",  64'(host_ready), 64'd0);
    check("full_pkts",   64'(pkt_count),  64'd2);
    host_we = 1'b1; host_flit = 64'hDEAD; host_tail = 1'b1;
    tick();
    host_we = 1'b0; host_tail = 1'b0;
    check("ovf_pulse",   64'(overflow),   64'd1);
    check("ovf_count",   64'(count),      64'd64);
    tick();
    check("ovf_clear",   64'(overflow),   64'd0);
    check("full_nostuck", 64'(stuck_err), 64'd0);
    out_ready = 1'b1;
    drain("full_drain");
    check("full_count_end", 64'(count), 64'd0);

    // 64 flits without a tail: deadlock flagged, nothing released.
    for (int i = 0; i < 64; i++) push(64'(32'hE000 + i), 1'b0);
    tick();
    check("stuck_set",   64'(stuck_err), 64'd1);
    check("stuck_valid", 64'(valid_out), 64'd0);
    tick();
    check("stuck_sticky", 64'(stuck_err), 64'd1);
    do_reset();
    check("stuck_rst",   64'(stuck_err), 64'd0);
    check("stuck_count", 64'(count),     64'd0);

    // Packet B pushed while packet C's tail pops; then reset with B1 pending.
    push(64'hC0, 1'b0);
    push(64'hC1, 1'b0);
    push(64'hC2, 1'b1);
    tick(); tick();
    push(64'hB0, 1'b0);
    push(64'hB1, 1'b1);
    check("ovl_count",   64'(count),     64'd2);
    check("ovl_pkts",    64'(pkt_count), 64'd1);
    check("ovl_gap",     64'(valid_out), 64'd0);
    tick();
    check("ovl_valid",   64'(valid_out), 64'd1);
    check("ovl_head",    flit_out,       64'hB0);
    tick();
    check("ovl_b1_head", flit_out,       64'hB1);
    do_reset();
    check("midrst_valid", 64'(valid_out), 64'd0);
    check("midrst_count", 64'(count),     64'd0);
    check("midrst_pkts",  64'(pkt_count), 64'd0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
